// File: rtl/video_in_pkg.sv
// Shared types and constants for the video_in DMA controller.
package video_in_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        WAIT_DATA,
        BURST,
        FRAME_DONE,
        ERROR
    } state_t;

    localparam int CTR_ENABLE  = 0;
    localparam int CTR_IRQ_EN  = 1;
    localparam int CTR_IRQ_CLR = 2;

    localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/video_in_addr_gen.sv
// Frame word index, burst position, buffer rotation and Wishbone
// byte address for the video_in DMA controller.
module video_in_addr_gen #(
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 76800,
    parameter int NB_BUFFERS  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        frame_begin,
    input  logic        frame_end,
    input  logic [31:0] base_i,
    output logic [31:0] adr_o,
    output logic [1:0]  cur_buffer_o,
    output logic        last_word_of_burst_o,
    output logic        frame_complete_o
);
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [31:0] FRAME_BYTES = 32'(FRAME_WORDS * 4);

    logic [IW-1:0] word_q, word_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    buf_q, buf_d;
    logic [31:0]   adr_q, adr_d;
    logic          last_burst;

    assign last_burst           = (burst_q == BW'(BURST_LEN - 1));
    assign last_word_of_burst_o = step & last_burst;
    assign frame_complete_o     = step & (word_q == IW'(FRAME_WORDS - 1));
    assign adr_o                = adr_q;
    assign cur_buffer_o         = buf_q;

    always_comb begin
        word_d  = word_q;
        burst_d = burst_q;
        buf_d   = buf_q;
        adr_d   = adr_q;
        // New frame reloads the address from the current buffer's base
        if (frame_begin) begin
            word_d  = '0;
            burst_d = '0;
            adr_d   = base_i + 32'(buf_q) * FRAME_BYTES;
        end else if (step) begin
            word_d  = word_q + 1'b1;
            burst_d = last_burst ? '0 : burst_q + 1'b1;
            adr_d   = adr_q + 32'd4;
        end
        if (frame_end) begin
            buf_d = (buf_q == 2'(NB_BUFFERS - 1)) ? 2'd0 : buf_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            burst_q <= '0;
            buf_q   <= '0;
            adr_q   <= '0;
        end else begin
            word_q  <= word_d;
            burst_q <= burst_d;
            buf_q   <= buf_d;
            adr_q   <= adr_d;
        end
    end
endmodule

// File: rtl/video_in_dma_ctrl.sv
// Moves packed pixel words from the video_in FIFO into rotating
// frame buffers using fixed-length Wishbone write bursts.
module video_in_dma_ctrl
    import video_in_pkg::*;
#(
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 76800,
    parameter int NB_BUFFERS  = 2,
    parameter int LEVEL_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic [31:0]        fifo_data,
    output logic               r_ack,
    input  logic [31:0]        wb_reg_ctr,
    input  logic [31:0]        wb_reg_data,
    output logic               p_wb_STB_O,
    output logic               p_wb_CYC_O,
    output logic               p_wb_LOCK_O,
    output logic [3:0]         p_wb_SEL_O,
    output logic [31:0]        p_wb_ADR_O,
    output logic [31:0]        p_wb_DAT_O,
    input  logic               p_wb_ACK_I,
    input  logic               p_wb_ERR_I,
    output logic               interrupt,
    output logic [1:0]         cur_buffer
);
    state_t state_q, state_d;
    logic   irq_q, irq_d;
    logic   enable, irq_en, irq_clr;
    logic   stb, step, err_evt, frame_begin, frame_end;
    logic   last_word, frame_cmp, level_ok;
    logic   unused_ctr;

    assign enable      = wb_reg_ctr[CTR_ENABLE];
    assign irq_en      = wb_reg_ctr[CTR_IRQ_EN];
    assign irq_clr     = wb_reg_ctr[CTR_IRQ_CLR];
    assign unused_ctr  = ^wb_reg_ctr[31:3];

    assign stb         = (state_q == BURST);
    assign step        = stb & p_wb_ACK_I & ~p_wb_ERR_I;
    assign err_evt     = stb & p_wb_ERR_I;
    assign frame_begin = (state_q == WAIT_SOF) & enable & frame_start;
    assign frame_end   = (state_q == FRAME_DONE);
    assign level_ok    = (fifo_level >= LEVEL_W'(BURST_LEN));

    assign p_wb_STB_O  = stb;
    assign p_wb_CYC_O  = stb;
    assign p_wb_LOCK_O = stb;
    assign p_wb_SEL_O  = SEL_ALL;
    assign p_wb_DAT_O  = fifo_data;
    assign r_ack       = step;
    assign interrupt   = irq_q;

    video_in_addr_gen #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS),
        .NB_BUFFERS (NB_BUFFERS)
    ) u_addr (
        .clk                 (clk),
        .reset               (reset),
        .step                (step),
        .frame_begin         (frame_begin),
        .frame_end           (frame_end),
        .base_i              (wb_reg_data),
        .adr_o               (p_wb_ADR_O),
        .cur_buffer_o        (cur_buffer),
        .last_word_of_burst_o(last_word),
        .frame_complete_o    (frame_cmp)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (enable) state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (!enable)          state_d = IDLE;
                else if (frame_start) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (!enable)       state_d = IDLE;
                else if (level_ok) state_d = BURST;
            end
            BURST: begin
                if (err_evt)        state_d = ERROR;
                else if (last_word) state_d = frame_cmp ? FRAME_DONE : WAIT_DATA;
            end
            FRAME_DONE: state_d = enable ? WAIT_SOF : IDLE;
            ERROR:      if (!enable) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // A new event takes priority over a clear so it is never lost
    always_comb begin
        irq_d = irq_q;
        if (irq_en & (frame_end | err_evt)) irq_d = 1'b1;
        else if (irq_clr)                   irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end
endmodule

// File: tb/tb_video_in_dma_ctrl.sv
// Randomized self-checking bench for video_in_dma_ctrl with a
// queue-based FIFO model and an arithmetic address model.
module tb_video_in_dma_ctrl;
    localparam int BL = 4;
    localparam int FW = 16;
    localparam int NB = 2;
    localparam int LW = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [LW-1:0] fifo_level = '0;
    logic [31:0]   fifo_data = '0;
    logic          r_ack;
    logic [31:0]   ctr = '0;
    logic [31:0]   data = BASE;
    logic          stb, cyc, lock;
    logic [3:0]    sel;
    logic [31:0]   adr, dat;
    logic          ack = 1'b0;
    logic          err = 1'b0;
    logic          interrupt;
    logic [1:0]    cur_buffer;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] q[$];
    bit pop_pend = 0;
    bit low_due = 0;
    int wi = 0;
    int fb = 0;

    always #5 clk = ~clk;

    video_in_dma_ctrl #(
        .BURST_LEN(BL), .FRAME_WORDS(FW), .NB_BUFFERS(NB), .LEVEL_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .fifo_level(fifo_level), .fifo_data(fifo_data), .r_ack(r_ack),
        .wb_reg_ctr(ctr), .wb_reg_data(data),
        .p_wb_STB_O(stb), .p_wb_CYC_O(cyc), .p_wb_LOCK_O(lock),
        .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_O(dat),
        .p_wb_ACK_I(ack), .p_wb_ERR_I(err),
        .interrupt(interrupt), .cur_buffer(cur_buffer)
    );

    task automatic update_fifo();
        fifo_level = LW'(q.size());
        fifo_data  = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) q.push_back($urandom);
        update_fifo();
    endtask

    task automatic tick();
        @(negedge clk);
        if (pop_pend) begin
            q.delete(0);
            pop_pend = 0;
        end
        update_fifo();
        ack = 1'b0;
        err = 1'b0;
        if (low_due) begin
            low_due = 0;
            nvec++;
            if (cyc !== 1'b0) begin
                nerr++;
                $display("FAIL burst_end cyc=%b want 0", cyc);
            end
        end
    endtask

    task automatic start_frame();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wi = 0;
    endtask

    task automatic serve(input int nacks, input int fw, input int err_at);
        int got = 0;
        int cycles = 0;
        int inb = 0;
        int waits;
        bit hold = 0;
        bit stop = 0;
        logic [31:0] pa = '0;
        logic [31:0] pd = '0;
        logic [31:0] ea;
        waits = (fw < 0) ? int'($urandom_range(0, 3)) : fw;
        while (got < nacks && !stop && cycles < 2000) begin
            tick();
            cycles++;
            if (stb === 1'b1) begin
                if (hold) begin
                    nvec++;
                    if (adr !== pa || dat !== pd) begin
                        nerr++;
                        $display("FAIL wait_hold adr=%h dat=%h want %h %h", adr, dat, pa, pd);
                    end
                end
                pa = adr;
                pd = dat;
                hold = 1;
                if (waits > 0) begin
                    waits--;
                end else if (got == err_at) begin
                    err = 1'b1;
                    #1;
                    nvec++;
                    if (r_ack !== 1'b0) begin
                        nerr++;
                        $display("FAIL err_pop r_ack=%b want 0", r_ack);
                    end
                    stop = 1;
                end else begin
                    ack = 1'b1;
                    #1;
                    ea = BASE + 32'(fb * FW * 4) + 32'(wi * 4);
                    nvec++;
                    if (r_ack !== 1'b1 || adr !== ea || dat !== q[0]) begin
                        nerr++;
                        $display("FAIL word%0d r_ack=%b adr=%h dat=%h want 1 %h %h",
                                 wi, r_ack, adr, dat, ea, q[0]);
                    end
                    pop_pend = 1;
                    got++;
                    wi++;
                    hold = 0;
                    inb++;
                    if (inb == BL) begin
                        inb = 0;
                        low_due = 1;
                    end
                    waits = (fw < 0) ? int'($urandom_range(0, 3)) : fw;
                end
            end
        end
        if (got < nacks && !stop) begin
            nvec++;
            nerr++;
            $display("FAIL serve_timeout acks=%0d want %0d", got, nacks);
        end
    endtask

    task automatic check_frame_end();
        fb = (fb + 1) % NB;
        tick();
        tick();
        tick();
        nvec++;
        if (interrupt !== 1'b1 || cur_buffer !== 2'(fb)) begin
            nerr++;
            $display("FAIL frame_end irq=%b buf=%0d want 1 %0d", interrupt, cur_buffer, fb);
        end
    endtask

    task automatic clear_irq();
        ctr = 32'h7;
        tick();
        ctr = 32'h3;
        tick();
        nvec++;
        if (interrupt !== 1'b0) begin
            nerr++;
            $display("FAIL irq_clear irq=%b want 0", interrupt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        nvec++;
        if ({cyc, stb, lock, r_ack, interrupt} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctl got=%b want 00000", {cyc, stb, lock, r_ack, interrupt});
        end
        nvec++;
        if (adr !== 32'h0 || cur_buffer !== 2'd0) begin
            nerr++;
            $display("FAIL reset_adr adr=%h buf=%0d want 0 0", adr, cur_buffer);
        end
        nvec++;
        if (sel !== 4'hF) begin
            nerr++;
            $display("FAIL reset_sel sel=%h want f", sel);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        ctr = 32'h3;
        tick();
        tick();
        start_frame();
        push(FW);
        serve(FW, 0, -1);
        check_frame_end();
    endtask

    task automatic test_second_frame();
        start_frame();
        push(FW);
        serve(FW, -1, -1);
        check_frame_end();
        clear_irq();
    endtask

    task automatic test_level();
        bit bad = 0;
        start_frame();
        push(BL - 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc !== 1'b0) bad = 1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL low_level cyc=1 want 0");
        end
        push(1);
        #1;
        nvec++;
        if (cyc !== 1'b0) begin
            nerr++;
            $display("FAIL level_latency cyc=%b want 0", cyc);
        end
        tick();
        nvec++;
        if (cyc !== 1'b1) begin
            nerr++;
            $display("FAIL level_start cyc=%b want 1", cyc);
        end
    endtask

    task automatic test_wait_states();
        push(FW - BL);
        serve(FW, 2, -1);
        check_frame_end();
        clear_irq();
    endtask

    task automatic test_error();
        bit bad = 0;
        start_frame();
        push(BL);
        serve(BL, 0, 1);
        tick();
        nvec++;
        if (cyc !== 1'b0 || interrupt !== 1'b1) begin
            nerr++;
            $display("FAIL err_resp cyc=%b irq=%b want 0 1", cyc, interrupt);
        end
        nvec++;
        if (q.size() != BL - 1 || cur_buffer !== 2'(fb)) begin
            nerr++;
            $display("FAIL err_pops left=%0d buf=%0d want %0d %0d",
                     q.size(), cur_buffer, BL - 1, fb);
        end
        push(2);
        start_frame();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cyc !== 1'b0) bad = 1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL err_stuck cyc=1 want 0");
        end
        ctr = 32'h0;
        tick();
        tick();
        ctr = 32'h3;
        tick();
        q.delete();
        update_fifo();
    endtask

    task automatic test_reset_mid_burst();
        bit seen = 0;
        bit bad = 0;
        start_frame();
        push(BL);
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (stb === 1'b1) seen = 1;
        end
        nvec++;
        if (!seen) begin
            nerr++;
            $display("FAIL rst_burst_start stb=0 want 1");
        end
        ack = 1'b1;
        reset = 1'b1;
        #1;
        nvec++;
        if ({cyc, stb, r_ack} !== 3'b0) begin
            nerr++;
            $display("FAIL rst_async got=%b want 000", {cyc, stb, r_ack});
        end
        tick();
        tick();
        reset = 1'b0;
        fb = 0;
        nvec++;
        if (cur_buffer !== 2'd0 || interrupt !== 1'b0) begin
            nerr++;
            $display("FAIL rst_state buf=%0d irq=%b want 0 0", cur_buffer, interrupt);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cyc !== 1'b0) bad = 1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL rst_no_sof cyc=1 want 0");
        end
        start_frame();
        push(FW - BL);
        serve(FW, -1, -1);
        check_frame_end();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_level();
        test_wait_states();
        test_error();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/video_in_dma_ctrl.md
Name: video_in_dma_ctrl

Overview:
Sequences transfer of packed pixel words (4 pixels per 32-bit word) from the video_in FIFO to frame buffers in RAM over the Wishbone master port. Waits for start-of-frame, issues fixed-length write bursts when enough words are buffered, and generates addresses across NB_BUFFERS rotating frame buffers. Raises the processor interrupt on frame completion or bus error. Sits between the FIFO and the Wishbone master, configured by wb_reg_ctr/wb_reg_data from the slave.

Parameters:
BURST_LEN, 8, words per Wishbone burst (power of 2, >=1)
FRAME_WORDS, 76800, words per frame (640x480/4); multiple of BURST_LEN
NB_BUFFERS, 2, frame buffers rotated in RAM (1..4)
LEVEL_W, 8, width of FIFO occupancy count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle start-of-frame pulse, clk domain
fifo_level  in  LEVEL_W  words currently in FIFO
fifo_data  in  32  FIFO head word (first-word-fall-through)
r_ack  out  1  pop FIFO head this cycle
wb_reg_ctr  in  32  bit0 enable, bit1 irq_en, bit2 irq_clear (level)
wb_reg_data  in  32  byte base address of buffer 0 (word aligned)
p_wb_STB_O/CYC_O/LOCK_O  out  1 each  Wishbone master strobe/cycle/lock
p_wb_SEL_O  out  4  byte selects
p_wb_ADR_O  out  32  byte address
p_wb_DAT_O  out  32  write data
p_wb_ACK_I, p_wb_ERR_I  in  1 each  slave ack / error
interrupt  out  1  level interrupt
cur_buffer  out  2  buffer index currently being written

Behaviour:
- Reset: state IDLE; STB/CYC/LOCK/r_ack/interrupt=0; SEL=4'hF constant; ADR=0; cur_buffer=0; word counter=0. Reset mid-burst drops CYC/STB immediately (async).
- Buffer k base = wb_reg_data + k*FRAME_WORDS*4; ADR = base + 4*word_idx. Address arithmetic 32-bit, wraps modulo 2^32, no check.
- DAT_O = fifo_data combinationally; r_ack = STB & ACK_I (pop same cycle as ack, one word per ack).
- States:
  IDLE: enable=0 -> stay; enable=1 -> WAIT_SOF.
  WAIT_SOF: frame_start -> word_idx=0, WAIT_DATA. enable=0 -> IDLE.
  WAIT_DATA: fifo_level>=BURST_LEN -> BURST next cycle (CYC=STB=LOCK=1 registered). enable=0 -> IDLE (mid-frame abort; frame discarded, no interrupt).
  BURST: CYC/STB/LOCK held high; each ACK cycle: word_idx+1, ADR+4, burst counter+1. No-ack cycles: hold ADR/DAT (wait states arbitrary). On BURST_LEN-th ACK: CYC/STB/LOCK low next cycle; if word_idx reaches FRAME_WORDS -> FRAME_DONE else WAIT_DATA. ERR_I (with STB) -> ERROR, no pop, CYC/STB low next cycle.
  FRAME_DONE (1 cycle): cur_buffer = (cur_buffer+1) mod NB_BUFFERS; set irq_pending if irq_en; -> WAIT_SOF (or IDLE if enable=0).
  ERROR: set irq_pending if irq_en; stays until enable=0, then IDLE. cur_buffer unchanged.
- frame_start outside WAIT_SOF ignored (late frame ends strictly by word count).
- enable deasserted during BURST: burst completes, then abort rule above applies.
- interrupt = irq_pending; irq_clear high clears it; simultaneous set and clear -> set wins (no lost event).
- Minimum 1 idle cycle (CYC low) between bursts; at least one cycle of latency from level condition to CYC.
- FIFO overflow not handled here; FIFO never read when empty, guaranteed by level check.

Decomposition:
- Package video_in_pkg: state enum typedef (IDLE, WAIT_SOF, WAIT_DATA, BURST, FRAME_DONE, ERROR), ctr bit index constants (CTR_ENABLE=0, CTR_IRQ_EN=1, CTR_IRQ_CLR=2), SEL_ALL=4'hF.
- Sub-module video_in_addr_gen: holds word_idx, cur_buffer, computes ADR; inputs step (ACK), frame_begin, frame_end; outputs last_word_of_burst, frame_complete.

Test Plan:
- FRAME_WORDS=16, BURST_LEN=4, base 0x1000, enable+irq_en, frame_start, level held 8, ACK every cycle -> 4 bursts, ADR 0x1000..0x103C, 16 pops, interrupt high after last ack, cur_buffer=1.
- Second frame same setup -> ADR 0x1040..0x107C, cur_buffer wraps to 0; irq_clear then -> interrupt 0.
- level=3 for 20 cycles then 4 -> CYC stays low until level=4, then burst starts next cycle.
- ACK with 2 wait cycles per word -> ADR/DAT stable during waits, exactly 4 pops per burst.
- ERR_I on 2nd word of burst -> 1 pop only, CYC low next cycle, interrupt high, state stuck until enable=0 then IDLE.
- Assert reset mid-burst -> CYC/STB/r_ack 0 same cycle; after release with enable=1, no transfer until new frame_start.
